// File: rtl/rcv_arb_pkg.sv
// ---------------------------------------------------------------------------
// rcv_arb_pkg
//   Shared definitions for the receiver-bank arbiter slice.
//   - state_t  : arbiter FSM states (IDLE, ACK, SEND)
//   - ch_width : channel tag width for a given channel count (min 1 bit)
// ---------------------------------------------------------------------------
package rcv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcv_arbiter_if.sv
// ---------------------------------------------------------------------------
// rcv_arbiter_if
//   Bundles the receiver-bank side and the byte-stream side of rcv_arbiter.
//   Receiver side : ch_en, data_ready, rx_data, overrun_error, framing_error
//                   (in to arbiter), data_read (out of arbiter)
//   Stream side   : out_valid/out_data/out_ch/out_ovr/out_frm (out),
//                   out_ready (in)
//   Status        : clr_status (in), err_status (out)
//   master : arbiter view; slave : environment view (receivers + consumer).
// ---------------------------------------------------------------------------
interface rcv_arbiter_if #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = rcv_arb_pkg::ch_width(NUM_CH)
);
    logic [NUM_CH-1:0]   ch_en;
    logic [NUM_CH-1:0]   data_ready;
    logic [NUM_CH*8-1:0] rx_data;
    logic [NUM_CH-1:0]   overrun_error;
    logic [NUM_CH-1:0]   framing_error;
    logic [NUM_CH-1:0]   data_read;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic [CH_W-1:0]     out_ch;
    logic                out_ovr;
    logic                out_frm;
    logic                clr_status;
    logic [NUM_CH-1:0]   err_status;

    modport master (
        input  ch_en, data_ready, rx_data, overrun_error, framing_error,
               out_ready, clr_status,
        output data_read, out_valid, out_data, out_ch, out_ovr, out_frm,
               err_status
    );

    modport slave (
        output ch_en, data_ready, rx_data, overrun_error, framing_error,
               out_ready, clr_status,
        input  data_read, out_valid, out_data, out_ch, out_ovr, out_frm,
               err_status
    );
endinterface

// File: rtl/rcv_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches i_req starting one above
//   i_last_grant, wrapping at NUM_CH, and returns the first requester.
//   i_req        : per-channel request vector
//   i_last_grant : channel granted most recently
//   o_grant      : selected channel (0 when no request)
//   o_any_req    : at least one request present
// ---------------------------------------------------------------------------
module rr_pick import rcv_arb_pkg::*; #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_last_grant,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_any_req
);

    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            int unsigned w_idx;
            w_idx = (32'(i_last_grant) + k) % NUM_CH;
            if (!o_any_req && i_req[w_idx]) begin
                o_grant   = CH_W'(w_idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcv_arbiter.sv
// ---------------------------------------------------------------------------
// rcv_arbiter
//   Round-robin service controller draining NUM_CH UART receivers into one
//   valid/ready byte stream tagged with the source channel.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : rcv_arbiter_if.master (receiver bank, output stream, status)
//   Flow per byte: IDLE captures the granted channel's byte and flags,
//   ACK pulses data_read for that channel, SEND holds out_valid until
//   out_ready. Sticky err_status records channels that delivered a byte
//   with overrun or framing error; clr_status clears it (a same-edge set
//   takes priority).
// ---------------------------------------------------------------------------
module rcv_arbiter import rcv_arb_pkg::*; #(
    parameter int NUM_CH = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    rcv_arbiter_if.master bus
);

    localparam int CH_W = ch_width(NUM_CH);

    state_t            r_state;
    logic [CH_W-1:0]   r_last_grant;
    logic [NUM_CH-1:0] r_data_read;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_ovr;
    logic              r_out_frm;
    logic [NUM_CH-1:0] r_err_status;

    logic [NUM_CH-1:0] w_req;
    logic [CH_W-1:0]   w_grant;
    logic              w_any_req;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [7:0]        w_sel_data;
    logic              w_sel_ovr;
    logic              w_sel_frm;
    logic [NUM_CH-1:0] w_err_set;

    assign w_req = bus.data_ready & bus.ch_en;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[w_grant] = 1'b1;
        w_sel_data          = bus.rx_data[32'(w_grant)*8 +: 8];
        w_sel_ovr           = bus.overrun_error[w_grant];
        w_sel_frm           = bus.framing_error[w_grant];
        // Error flags are latched only on the capture edge of a granted byte.
        w_err_set           = '0;
        if (r_state == IDLE && w_any_req && (w_sel_ovr || w_sel_frm)) begin
            w_err_set = w_grant_oh;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_data_read  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_ovr    <= 1'b0;
            r_out_frm    <= 1'b0;
            r_err_status <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_out_data   <= w_sel_data;
                        r_out_ovr    <= w_sel_ovr;
                        r_out_frm    <= w_sel_frm;
                        r_out_ch     <= w_grant;
                        r_last_grant <= w_grant;
                        r_data_read  <= w_grant_oh;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    r_data_read <= '0;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_data_read <= '0;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
            r_err_status <= (bus.clr_status ? '0 : r_err_status) | w_err_set;
        end
    end

    assign bus.data_read  = r_data_read;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_ch     = r_out_ch;
    assign bus.out_ovr    = r_out_ovr;
    assign bus.out_frm    = r_out_frm;
    assign bus.err_status = r_err_status;

endmodule

// File: tb/tb_rcv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rcv_arbiter
//   Directed bench for rcv_arbiter (NUM_CH = 4). A transaction-level model
//   tracks which byte is in flight and predicts every output; it is compared
//   against the DUT on each falling edge. Literal expectations pin the
//   scenarios: reset, fairness, backpressure, masking, errors, mid-SEND reset.
// ---------------------------------------------------------------------------
module tb_rcv_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    rcv_arbiter_if #(.NUM_CH(N)) bus ();

    rcv_arbiter #(.NUM_CH(N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit hold  = 1'b0;

    // Model: m_stage 0 = waiting for a request, 1 = acknowledge cycle,
    // 2 = byte offered downstream.
    int         m_stage;
    int         m_last;
    int         m_ch;
    logic [7:0] m_data;
    logic       m_ovr;
    logic       m_frm;
    logic [N-1:0] m_err;

    task automatic m_reset();
        m_stage = 0;
        m_last  = N - 1;
        m_ch    = 0;
        m_data  = '0;
        m_ovr   = 1'b0;
        m_frm   = 1'b0;
        m_err   = '0;
    endtask

    task automatic m_step();
        logic [N-1:0] req;
        logic [N-1:0] set;
        int pick;
        req  = bus.data_ready & bus.ch_en;
        set  = '0;
        pick = -1;
        case (m_stage)
            0: begin
                for (int k = 1; k <= N; k++) begin
                    if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
                end
                if (pick >= 0) begin
                    m_data  = bus.rx_data[8*pick +: 8];
                    m_ovr   = bus.overrun_error[pick];
                    m_frm   = bus.framing_error[pick];
                    m_ch    = pick;
                    m_last  = pick;
                    if (bus.overrun_error[pick] || bus.framing_error[pick]) set[pick] = 1'b1;
                    m_stage = 1;
                end
            end
            1: m_stage = 2;
            default: if (bus.out_ready) m_stage = 0;
        endcase
        m_err = (bus.clr_status ? '0 : m_err) | set;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge n_rst);
            if (n_rst !== 1'b1) m_reset();
            else m_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic [N-1:0] exp_dr;
        exp_dr = (m_stage == 1) ? N'(1 << m_ch) : '0;
        chk("m_data_read",  32'(bus.data_read),  32'(exp_dr));
        chk("m_out_valid",  32'(bus.out_valid),  32'(m_stage == 2));
        chk("m_out_data",   32'(bus.out_data),   32'(m_data));
        chk("m_out_ch",     32'(bus.out_ch),     32'(m_ch));
        chk("m_out_ovr",    32'(bus.out_ovr),    32'(m_ovr));
        chk("m_out_frm",    32'(bus.out_frm),    32'(m_frm));
        chk("m_err_status", 32'(bus.err_status), 32'(m_err));
    endtask

    // One cycle: compare against the model mid-cycle, then advance to just
    // after the next rising edge. Receivers drop data_ready once acknowledged.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_cmp();
            @(posedge clk);
            #1;
            if (!hold && bus.data_read != '0) bus.data_ready = bus.data_ready & ~bus.data_read;
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_grant(input string name, output int ch);
        ch = -1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.data_read != '0) begin
                ch = oh2idx(bus.data_read);
                break;
            end
        end
        if (ch < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got no data_read expected a grant within 12 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int gseq[$];
        int gcyc[$];
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};

        n_rst             = 1'b0;
        bus.ch_en         = '1;
        bus.data_ready    = '0;
        bus.rx_data       = '0;
        bus.overrun_error = '0;
        bus.framing_error = '0;
        bus.out_ready     = 1'b1;
        bus.clr_status    = 1'b0;

        // Reset state
        step(2);
        chk("rst_data_read",  32'(bus.data_read),  0);
        chk("rst_out_valid",  32'(bus.out_valid),  0);
        chk("rst_out_data",   32'(bus.out_data),   0);
        chk("rst_out_ch",     32'(bus.out_ch),     0);
        chk("rst_err_status", 32'(bus.err_status), 0);

        // First transaction after reset
        bus.data_ready    = 4'b0001;
        bus.rx_data[7:0]  = 8'hA5;
        n_rst             = 1'b1;
        step(1);
        chk("first_data_read", 32'(bus.data_read), 32'h1);
        chk("first_valid_lo",  32'(bus.out_valid), 0);
        step(1);
        chk("first_data_read_off", 32'(bus.data_read), 0);
        chk("first_out_valid", 32'(bus.out_valid), 1);
        chk("first_out_data",  32'(bus.out_data),  32'hA5);
        chk("first_out_ch",    32'(bus.out_ch),    0);
        step(1);
        chk("first_accepted",  32'(bus.out_valid), 0);

        // Fairness with every channel requesting continuously
        n_rst = 1'b0;
        hold  = 1'b1;
        for (int i = 0; i < N; i++) bus.rx_data[8*i +: 8] = 8'h10 + 8'(i);
        bus.data_ready = '1;
        step(1);
        n_rst = 1'b1;
        for (int c = 1; c <= 30 && gseq.size() < 5; c++) begin
            step(1);
            if (bus.data_read != '0) begin
                gseq.push_back(oh2idx(bus.data_read));
                gcyc.push_back(c);
            end
        end
        if (gseq.size() != 5) begin
            n_vec++;
            n_bad++;
            $display("FAIL fair_count: got %0d grants expected 5", gseq.size());
        end else begin
            for (int i = 0; i < 5; i++) chk($sformatf("fair_grant%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
            for (int i = 1; i < 5; i++) chk($sformatf("fair_period%0d", i), 32'(gcyc[i] - gcyc[i-1]), 3);
        end
        hold           = 1'b0;
        bus.data_ready = '0;
        step(4);

        // Backpressure on a channel-2 byte while channel 0 is waiting
        bus.out_ready      = 1'b0;
        bus.rx_data[23:16] = 8'h3C;
        bus.data_ready     = 4'b0100;
        wait_grant("bp_grant", g);
        chk("bp_grant_ch", 32'(g), 2);
        bus.rx_data[7:0] = 8'h77;
        bus.data_ready   = bus.data_ready | 4'b0001;
        step(1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",     32'(bus.out_valid), 1);
            chk("bp_data",      32'(bus.out_data),  32'h3C);
            chk("bp_ch",        32'(bus.out_ch),    2);
            chk("bp_no_dread",  32'(bus.data_read), 0);
            step(1);
        end
        bus.out_ready = 1'b1;
        step(1);
        chk("bp_accepted", 32'(bus.out_valid), 0);
        wait_grant("bp_next", g);
        chk("bp_next_ch0", 32'(g), 0);
        step(3);

        // Channel mask
        bus.ch_en      = 4'b1011;
        bus.data_ready = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("mask_no_grant", 32'(bus.data_read), 0);
        end
        bus.ch_en = 4'b1111;
        wait_grant("mask_enable", g);
        chk("mask_ch2", 32'(g), 2);
        step(3);

        // Framing error, then set-vs-clear on the same edge, then clear alone
        bus.rx_data[15:8] = 8'h5A;
        bus.framing_error = 4'b0010;
        bus.data_ready    = 4'b0010;
        wait_grant("frm_grant", g);
        chk("frm_ch1", 32'(g), 1);
        step(1);
        chk("frm_out_frm",  32'(bus.out_frm),    1);
        chk("frm_out_ovr",  32'(bus.out_ovr),    0);
        chk("frm_out_data", 32'(bus.out_data),   32'h5A);
        chk("frm_err",      32'(bus.err_status), 32'h2);
        step(2);
        bus.data_ready = 4'b0010;
        bus.clr_status = 1'b1;
        step(1);
        bus.clr_status = 1'b0;
        chk("frm_set_wins", 32'(bus.err_status), 32'h2);
        chk("frm_regrant",  32'(bus.data_read),  32'h2);
        step(3);
        bus.framing_error = '0;

        bus.overrun_error  = 4'b1000;
        bus.rx_data[31:24] = 8'hE7;
        bus.data_ready     = 4'b1000;
        wait_grant("ovr_grant", g);
        chk("ovr_ch3", 32'(g), 3);
        step(1);
        chk("ovr_out_ovr", 32'(bus.out_ovr),    1);
        chk("ovr_err",     32'(bus.err_status), 32'hA);
        step(2);
        bus.overrun_error = '0;
        bus.clr_status    = 1'b1;
        step(1);
        bus.clr_status = 1'b0;
        chk("clr_alone", 32'(bus.err_status), 0);

        // Reset while a byte is being offered
        bus.out_ready      = 1'b0;
        bus.rx_data[23:16] = 8'hC3;
        bus.data_ready     = 4'b0100;
        wait_grant("rst_grant", g);
        step(1);
        chk("rst_pre_valid", 32'(bus.out_valid), 1);
        bus.data_ready = 4'b0101;
        n_rst          = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 0);
        chk("rst_async_data",  32'(bus.out_data),  0);
        step(1);
        n_rst         = 1'b1;
        bus.out_ready = 1'b1;
        wait_grant("rst_restart", g);
        chk("rst_restart_ch0", 32'(g), 0);
        wait_grant("rst_second", g);
        chk("rst_second_ch2", 32'(g), 2);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rcv_arbiter.md
# rcv_arbiter

Round-robin service controller that drains up to NUM_CH independent `rcv_block` UART receivers into a single byte stream. It watches each receiver's `data_ready`, captures the byte and error flags of one granted channel, pulses that channel's `data_read`, and presents the byte with a channel tag on a valid/ready output port. It sits between the receiver bank and the downstream byte consumer (FIFO or packet parser), and keeps sticky per-channel error status for software.

## Interface
- NUM_CH, 4, number of receiver channels serviced (1..16)
- CH_W, derived: 1 if NUM_CH==1, else $clog2(NUM_CH); width of channel tag
- clk  input  1  system clock; all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- ch_en  input  NUM_CH  per-channel service enable; disabled channels are never granted
- data_ready  input  NUM_CH  per-channel byte-available flags from receivers
- rx_data  input  NUM_CH*8  flattened receiver bytes; channel i at [8i+7:8i]
- overrun_error  input  NUM_CH  per-channel overrun flags
- framing_error  input  NUM_CH  per-channel framing flags
- data_read  output  NUM_CH  one-hot, one-cycle acknowledge to the granted receiver
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accepts byte when high with out_valid
- out_data  output  8  captured byte
- out_ch  output  CH_W  channel index of out_data
- out_ovr  output  1  overrun flag captured with out_data
- out_frm  output  1  framing flag captured with out_data
- clr_status  input  1  one-cycle pulse clearing err_status
- err_status  output  NUM_CH  sticky: channel delivered a byte with overrun or framing flag

## Operation
- FSM states: IDLE, ACK, SEND.
- IDLE: req = data_ready & ch_en. If req != 0, pick the first set bit searching from (last_grant+1) mod NUM_CH upward with wrap. On that edge: register grant, load out_data/out_ovr/out_frm from the granted channel, set out_ch and last_grant to grant, go to ACK. If req == 0, stay in IDLE.
- ACK: data_read[grant] = 1 (Moore, exactly one cycle); all other bits are 0. Unconditionally go to SEND.
- SEND: out_valid = 1. Output registers are held stable. When out_ready is high, go to IDLE.
- Arbitration is not evaluated in ACK or SEND. Requests arriving then wait.
- ch_en changes take effect only at the next IDLE evaluation. A transaction in progress is never aborted.
- err_status[i] sets on the IDLE capture edge if the granted channel i has overrun_error | framing_error. clr_status clears all bits. If set and clear hit the same edge, set wins for that bit.
- Reset values: state IDLE, last_grant = NUM_CH-1 (so channel 0 wins first), data_read = 0, out_valid = 0, out_data = 0, out_ch = 0, out_ovr = 0, out_frm = 0, err_status = 0.
- Reset mid-transaction drops the captured byte. A receiver whose byte was captured but not yet ACKed keeps data_ready high and is serviced again after reset.

## Timing
- Capture latency: request visible in IDLE at edge k → data_read high during cycle k..k+1 → out_valid high from edge k+1.
- Minimum per-byte period: 3 cycles (IDLE, ACK, SEND with out_ready already high).
- The receiver clears data_ready at the end of the ACK cycle. It is low by the next IDLE, so there is no double service.
- out_valid stays high, and out_data/out_ch/out_ovr/out_frm stay constant, until the out_ready handshake.
- data_read is never high while out_valid is high.

## Structure
- Shared package rcv_arb_pkg holds the state enum typedef (IDLE, ACK, SEND).
- Natural sub-module: rr_pick, a combinational round-robin selector. Inputs are req[NUM_CH] and last_grant; outputs are grant index and any_req. Instantiate it once.
- All outputs come from registers or are decoded from the state register only; out_valid and data_read have no combinational path from inputs.

## Test plan
- Reset: hold n_rst low → every output 0. Release with data_ready=4'b0001, rx_data ch0=8'hA5, out_ready=1 → data_read=4'b0001 for 1 cycle, then out_valid with out_data=8'hA5, out_ch=0.
- Fairness: NUM_CH=4, all data_ready held high, ch_en=4'hF, out_ready=1 → grants 0,1,2,3,0 in order, one grant every 3 cycles.
- Backpressure: out_ready=0 for 10 cycles after capture of ch2 byte 8'h3C → out_valid stays high with data 8'h3C, ch 2; no data_read pulses; accepted on the first cycle out_ready=1.
- Mask: ch_en=4'b1011, data_ready=4'b0100 → no grant. Set ch_en bit 2 → ch2 is serviced.
- Errors: ch1 byte with framing_error=1 → out_frm=1 and err_status[1]=1. Assert clr_status on the same edge as a new ch1 framing capture → err_status[1] stays 1. Assert clr_status alone → err_status clears to 0.
- Reset mid-SEND: assert n_rst during out_valid → out_valid=0 immediately. After release, a receiver still asserting data_ready is re-serviced starting from channel 0.
